axi_decerr_slave_0: RTL and testbench

- Default slave for AXI_fabric_0.
- Sits downstream of the address decoder and receives every AW/AR transaction whose one-hot slave select is all zeros (address unmapped for that master).
- Completes each such transaction per AXI4 protocol with DECERR responses, so the fabric never hangs on an unmapped access.
- The write and read channels are independent FSMs; one transaction of each direction is in flight at a time.

---
 rtl/axi_decerr_slave_0.sv | 177 +++++++++++++++++
 tb/tb_axi_decerr_slave_0.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_decerr_slave_0.sv
// Default AXI4 slave: terminates every transaction it is handed with a DECERR response.
// The write and read channels are independent FSMs, and all outputs come from registers.
module axi_decerr_slave_0 #(
  parameter int PARAM_WIDTH = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ID_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int unused_param_width = PARAM_WIDTH;

  // Address, length and write payload are accepted and dropped; wlast alone ends a write burst.
  logic unused_inputs;
  assign unused_inputs = ^{s_awaddr, s_awlen, s_wdata, s_wstrb, s_araddr};

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  w_state_t            w_state, w_state_next;
  logic [ID_WIDTH-1:0] aw_id, aw_id_next;
  logic                awready_next, wready_next, bvalid_next;
  logic [ID_WIDTH-1:0] bid_next;
  logic [1:0]          bresp_next;

  r_state_t            r_state, r_state_next;
  logic [ID_WIDTH-1:0] ar_id, ar_id_next;
  logic [7:0]          beat_cnt, beat_cnt_next;
  logic                arready_next, rvalid_next, rlast_next;
  logic [ID_WIDTH-1:0] rid_next;
  logic [1:0]          rresp_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      aw_id     <= '0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bid     <= '0;
      s_bresp   <= RESP_OKAY;
    end else begin
      w_state   <= w_state_next;
      aw_id     <= aw_id_next;
      s_awready <= awready_next;
      s_wready  <= wready_next;
      s_bvalid  <= bvalid_next;
      s_bid     <= bid_next;
      s_bresp   <= bresp_next;
    end
  end

  // Outputs are derived from the next state, so they land in registers on the same edge as the state.
  always_comb begin
    w_state_next = w_state;
    aw_id_next   = aw_id;
    case (w_state)
      W_IDLE: begin
        if (s_awvalid && s_awready) begin
          w_state_next = W_DATA;
          aw_id_next   = s_awid;
        end
      end
      W_DATA: begin
        if (s_wvalid && s_wready && s_wlast) begin
          w_state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bvalid && s_bready) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase

    awready_next = (w_state_next == W_IDLE);
    wready_next  = (w_state_next == W_DATA);
    bvalid_next  = (w_state_next == W_RESP);
    bid_next     = bvalid_next ? aw_id_next : '0;
    bresp_next   = bvalid_next ? RESP_DECERR : RESP_OKAY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      ar_id     <= '0;
      beat_cnt  <= '0;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rid     <= '0;
      s_rresp   <= RESP_OKAY;
      s_rlast   <= 1'b0;
    end else begin
      r_state   <= r_state_next;
      ar_id     <= ar_id_next;
      beat_cnt  <= beat_cnt_next;
      s_arready <= arready_next;
      s_rvalid  <= rvalid_next;
      s_rid     <= rid_next;
      s_rresp   <= rresp_next;
      s_rlast   <= rlast_next;
    end
  end

  // The counter holds beats remaining after the one on the bus; it stops at zero and never wraps.
  always_comb begin
    r_state_next  = r_state;
    ar_id_next    = ar_id;
    beat_cnt_next = beat_cnt;
    case (r_state)
      R_IDLE: begin
        if (s_arvalid && s_arready) begin
          r_state_next  = R_DATA;
          ar_id_next    = s_arid;
          beat_cnt_next = s_arlen;
        end
      end
      R_DATA: begin
        if (s_rvalid && s_rready) begin
          if (beat_cnt == 8'd0) begin
            r_state_next = R_IDLE;
          end else begin
            beat_cnt_next = beat_cnt - 8'd1;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase

    arready_next = (r_state_next == R_IDLE);
    rvalid_next  = (r_state_next == R_DATA);
    rid_next     = rvalid_next ? ar_id_next : '0;
    rresp_next   = rvalid_next ? RESP_DECERR : RESP_OKAY;
    rlast_next   = rvalid_next && (beat_cnt_next == 8'd0);
  end

  assign s_rdata = '0;

endmodule

// File: tb/tb_axi_decerr_slave_0.sv
// Directed bench for axi_decerr_slave_0: reset, bursts, concurrency, back-pressure and mid-burst reset.
module tb_axi_decerr_slave_0;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_awid;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_wvalid;
  logic        s_wready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic        s_arvalid;
  logic        s_arready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready;

  int vectors = 0;
  int miscompares = 0;

  axi_decerr_slave_0 dut (
    .clk(clk), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where registered outputs are settled.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " awready"}, 32'(s_awready), 32'h0);
    checkOutput({tag, " wready"},  32'(s_wready),  32'h0);
    checkOutput({tag, " bvalid"},  32'(s_bvalid),  32'h0);
    checkOutput({tag, " bid"},     32'(s_bid),     32'h0);
    checkOutput({tag, " bresp"},   32'(s_bresp),   32'h0);
    checkOutput({tag, " arready"}, 32'(s_arready), 32'h0);
    checkOutput({tag, " rvalid"},  32'(s_rvalid),  32'h0);
    checkOutput({tag, " rid"},     32'(s_rid),     32'h0);
    checkOutput({tag, " rresp"},   32'(s_rresp),   32'h0);
    checkOutput({tag, " rlast"},   32'(s_rlast),   32'h0);
    checkOutput({tag, " rdata"},   s_rdata,        32'h0);
  endtask

  initial begin
    rst = 1'b1;
    s_awid = '0; s_awaddr = 32'h4000_0000; s_awlen = 8'd3; s_awvalid = 1'b0;
    s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    s_arid = '0; s_araddr = 32'h5000_0000; s_arlen = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;

    // Reset held, then released with no traffic.
    applyStimulus();
    applyStimulus();
    checkAllZero("reset");
    rst = 1'b0;
    applyStimulus();
    checkOutput("rel awready", 32'(s_awready), 32'h1);
    checkOutput("rel arready", 32'(s_arready), 32'h1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      checkOutput("idle bvalid", 32'(s_bvalid), 32'h0);
      checkOutput("idle rvalid", 32'(s_rvalid), 32'h0);
      checkOutput("idle wready", 32'(s_wready), 32'h0);
      checkOutput("idle awready", 32'(s_awready), 32'h1);
    end

    // Four-beat write, id 3, bready high throughout.
    s_bready = 1'b1;
    s_awid = 4'h3; s_awvalid = 1'b1;
    applyStimulus();
    s_awvalid = 1'b0;
    checkOutput("wr awready after AW", 32'(s_awready), 32'h0);
    for (int b = 0; b < 4; b++) begin
      checkOutput("wr wready beat", 32'(s_wready), 32'h1);
      checkOutput("wr bvalid early", 32'(s_bvalid), 32'h0);
      s_wvalid = 1'b1;
      s_wlast = (b == 3);
      applyStimulus();
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    checkOutput("wr wready after last", 32'(s_wready), 32'h0);
    checkOutput("wr bvalid", 32'(s_bvalid), 32'h1);
    checkOutput("wr bid", 32'(s_bid), 32'h3);
    checkOutput("wr bresp", 32'(s_bresp), 32'h3);
    applyStimulus();
    checkOutput("wr bvalid done", 32'(s_bvalid), 32'h0);
    checkOutput("wr awready again", 32'(s_awready), 32'h1);
    s_bready = 1'b0;

    // W beat offered with no AW: must not be taken.
    s_wvalid = 1'b1; s_wlast = 1'b1;
    applyStimulus();
    checkOutput("orphan W wready", 32'(s_wready), 32'h0);
    applyStimulus();
    checkOutput("orphan W bvalid", 32'(s_bvalid), 32'h0);
    s_wvalid = 1'b0; s_wlast = 1'b0;

    // Read id A, arlen 3, rready alternating so each beat is seen stalled once.
    s_arid = 4'hA; s_arlen = 8'd3; s_arvalid = 1'b1;
    applyStimulus();
    s_arvalid = 1'b0;
    checkOutput("rd arready busy", 32'(s_arready), 32'h0);
    for (int b = 0; b < 4; b++) begin
      checkOutput("rd rvalid", 32'(s_rvalid), 32'h1);
      checkOutput("rd rid", 32'(s_rid), 32'hA);
      checkOutput("rd rresp", 32'(s_rresp), 32'h3);
      checkOutput("rd rdata", s_rdata, 32'h0);
      checkOutput("rd rlast", 32'(s_rlast), 32'(b == 3));
      s_rready = 1'b0;
      applyStimulus();
      checkOutput("rd stall rvalid", 32'(s_rvalid), 32'h1);
      checkOutput("rd stall rid", 32'(s_rid), 32'hA);
      checkOutput("rd stall rlast", 32'(s_rlast), 32'(b == 3));
      s_rready = 1'b1;
      applyStimulus();
    end
    s_rready = 1'b0;
    checkOutput("rd rvalid done", 32'(s_rvalid), 32'h0);
    checkOutput("rd rlast done", 32'(s_rlast), 32'h0);
    checkOutput("rd arready again", 32'(s_arready), 32'h1);

    // Simultaneous AW id 1 and AR id 2 (single beat); B back-pressured for five cycles.
    s_awid = 4'h1; s_awvalid = 1'b1;
    s_arid = 4'h2; s_arlen = 8'd0; s_arvalid = 1'b1;
    s_rready = 1'b1; s_bready = 1'b0;
    applyStimulus();
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    checkOutput("cc wready", 32'(s_wready), 32'h1);
    checkOutput("cc rvalid", 32'(s_rvalid), 32'h1);
    checkOutput("cc rid", 32'(s_rid), 32'h2);
    checkOutput("cc rlast", 32'(s_rlast), 32'h1);
    s_wvalid = 1'b1; s_wlast = 1'b1;
    applyStimulus();
    s_wvalid = 1'b0; s_wlast = 1'b0;
    checkOutput("cc rvalid done", 32'(s_rvalid), 32'h0);
    checkOutput("cc arready", 32'(s_arready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("cc bvalid hold", 32'(s_bvalid), 32'h1);
      checkOutput("cc bid hold", 32'(s_bid), 32'h1);
      checkOutput("cc bresp hold", 32'(s_bresp), 32'h3);
      checkOutput("cc awready busy", 32'(s_awready), 32'h0);
      applyStimulus();
    end
    s_bready = 1'b1;
    applyStimulus();
    s_bready = 1'b0;
    checkOutput("cc bvalid done", 32'(s_bvalid), 32'h0);
    checkOutput("cc awready again", 32'(s_awready), 32'h1);

    // Maximum burst: arlen 255 with an all-ones ID.
    s_arid = 4'hF; s_arlen = 8'd255; s_arvalid = 1'b1; s_rready = 1'b1;
    applyStimulus();
    s_arvalid = 1'b0;
    for (int b = 1; b <= 256; b++) begin
      checkOutput("long rvalid", 32'(s_rvalid), 32'h1);
      checkOutput("long rid", 32'(s_rid), 32'hF);
      checkOutput("long rlast", 32'(s_rlast), 32'(b == 256));
      applyStimulus();
    end
    checkOutput("long rvalid done", 32'(s_rvalid), 32'h0);
    checkOutput("long arready", 32'(s_arready), 32'h1);
    s_rready = 1'b0;

    // Reset during beat 2 of an arlen 7 read while a write sits in W_DATA.
    s_awid = 4'h6; s_awvalid = 1'b1;
    s_arid = 4'h5; s_arlen = 8'd7; s_arvalid = 1'b1; s_rready = 1'b1;
    applyStimulus();
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    applyStimulus();
    checkOutput("mid rvalid", 32'(s_rvalid), 32'h1);
    checkOutput("mid rlast", 32'(s_rlast), 32'h0);
    checkOutput("mid wready", 32'(s_wready), 32'h1);
    rst = 1'b1;
    #1;
    checkAllZero("async rst");
    s_bready = 1'b1;
    applyStimulus();
    checkAllZero("rst held");
    rst = 1'b0;
    applyStimulus();
    checkOutput("post rst awready", 32'(s_awready), 32'h1);
    checkOutput("post rst arready", 32'(s_arready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("post rst rvalid", 32'(s_rvalid), 32'h0);
      checkOutput("post rst bvalid", 32'(s_bvalid), 32'h0);
      checkOutput("post rst wready", 32'(s_wready), 32'h0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
